// File: rtl/fir_input_arbiter_if.sv
// Bundle of the N requester streams and the merged FIR input stream.
// The arbiter attaches to the slave modport; the feeding/consuming side uses master.
interface fir_input_arbiter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_LOG = 2
);
    localparam int unsigned N = 2 ** N_LOG;

    logic [N-1:0]       s_axis_tvalid;
    logic [N-1:0]       s_axis_tready;
    logic [N*WIDTH-1:0] s_axis_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic [WIDTH-1:0]   m_axis_tdata;
    logic [N_LOG-1:0]   m_axis_tid;

    modport master (
        output s_axis_tvalid, s_axis_tdata, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tid
    );

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tid
    );
endinterface

// File: rtl/fir_input_arbiter.sv
// Round-robin burst arbiter merging N upstream FIFOs into one registered FIR input stream.
// A grant lasts up to BURST beats or until the granted requester drops valid.
module fir_input_arbiter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned N_LOG     = 2,
    parameter int unsigned BURST_LOG = 3
) (
    input logic                 clk,
    input logic                 rst,
    fir_input_arbiter_if.slave  bus
);
    localparam int unsigned N     = 2 ** N_LOG;
    localparam int unsigned BURST = 2 ** BURST_LOG;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state;
    logic [N_LOG-1:0]     g;
    logic [N_LOG-1:0]     last;
    logic [BURST_LOG-1:0] cnt;
    logic                 m_valid;
    logic [WIDTH-1:0]     m_data;
    logic [N_LOG-1:0]     m_tid;

    logic [WIDTH-1:0]     lane [N];
    logic [N_LOG-1:0]     pick;
    logic [N_LOG-1:0]     cand;
    logic                 pick_vld;
    logic                 ready_c;
    logic                 xfer_c;
    logic                 last_beat_c;

    // Unpack the flat requester data bus into lanes.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            lane[i] = bus.s_axis_tdata[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin search starting after last; scanning far-to-near lets the nearest valid win.
    always_comb begin
        pick     = '0;
        cand     = '0;
        pick_vld = 1'b0;
        for (int k = N; k >= 1; k--) begin
            cand = last + N_LOG'(k);
            if (bus.s_axis_tvalid[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    assign ready_c     = (state == GRANT) && (!m_valid || bus.m_axis_tready);
    assign xfer_c      = ready_c && bus.s_axis_tvalid[g];
    assign last_beat_c = (cnt == BURST_LOG'(BURST - 1));

    assign bus.s_axis_tready = ready_c ? (N'(1) << g) : '0;
    assign bus.m_axis_tvalid = m_valid;
    assign bus.m_axis_tdata  = m_data;
    assign bus.m_axis_tid    = m_tid;

    // Arbitration FSM and the single output register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            g       <= '0;
            last    <= N_LOG'(N - 1);
            cnt     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_tid   <= '0;
        end else begin
            if (xfer_c) begin
                m_data  <= lane[g];
                m_tid   <= g;
                m_valid <= 1'b1;
                cnt     <= cnt + BURST_LOG'(1);
            end else if (bus.m_axis_tready) begin
                m_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        g     <= pick;
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    // Downstream stalls never release; only a full burst or a dropped valid does.
                    if (!bus.s_axis_tvalid[g] || (xfer_c && last_beat_c)) begin
                        state <= IDLE;
                        last  <= g;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_input_arbiter.sv
// Directed and random checks of fir_input_arbiter: queue-backed sources, a scoreboard
// monitor on the merged stream, and burst/idle bookkeeping on the request side.
module tb_fir_input_arbiter;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned N_LOG = 2;
    localparam int unsigned N     = 4;

    typedef struct packed {
        logic [N_LOG-1:0] tid;
        logic [WIDTH-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fir_input_arbiter_if #(.WIDTH(WIDTH), .N_LOG(N_LOG)) bus ();

    fir_input_arbiter #(.WIDTH(WIDTH), .N_LOG(N_LOG), .BURST_LOG(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] src_q [N][$];
    logic [WIDTH-1:0] exp_tid_q [N][$];
    beat_t            exp_q [$];
    bit per_tid   = 1'b0;
    bit sb_off    = 1'b0;
    bit rand_mode = 1'b0;
    int stall_left = 0;

    int fires, run, run_tid, idle_total, idle_pending;
    bit seen_fire;
    int max_run [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int i, input logic [WIDTH-1:0] d);
        src_q[i].push_back(d);
        if (per_tid) exp_tid_q[i].push_back(d);
        else         exp_q.push_back({N_LOG'(i), d});
    endtask

    task automatic clear_metrics();
        fires = 0; run = 0; run_tid = -1; idle_total = 0; idle_pending = 0; seen_fire = 1'b0;
        for (int i = 0; i < N; i++) max_run[i] = 0;
    endtask

    function automatic bit all_empty();
        bit e;
        e = (exp_q.size() == 0) && !bus.m_axis_tvalid;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0 || exp_tid_q[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic drain(input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk); #3;
            done = all_empty();
        end
        check("drain_timeout", 64'(done), 64'd1);
    endtask

    task automatic wait_fires(input int n, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk); #3;
            done = (fires >= n);
        end
        check("wait_fires_timeout", 64'(done), 64'd1);
    endtask

    // Reset pulse with the reset-state outputs checked while rst is high.
    task automatic do_reset();
        @(negedge clk); #3;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_tid_q[i].delete();
        end
        exp_q.delete();
        @(negedge clk); #3;
        check("rst_m_valid", 64'(bus.m_axis_tvalid), 64'd0);
        check("rst_m_data",  64'(bus.m_axis_tdata),  64'd0);
        check("rst_m_tid",   64'(bus.m_axis_tid),    64'd0);
        check("rst_s_ready", 64'(bus.s_axis_tready), 64'd0);
        @(negedge clk); #3;
        rst = 1'b0;
        clear_metrics();
    endtask

    // Source driver: present queue heads, then retire any head the DUT is accepting.
    initial begin
        logic [N-1:0]       vv;
        logic [N*WIDTH-1:0] dd;
        logic [N-1:0]       fire;
        bit                 stalled;
        int                 idx;
        bus.s_axis_tvalid = '0;
        bus.s_axis_tdata  = '0;
        bus.m_axis_tready = 1'b1;
        clear_metrics();
        forever begin
            @(negedge clk);
            if (stall_left > 0) begin
                bus.m_axis_tready = 1'b0;
                stall_left--;
            end else if (rand_mode) begin
                bus.m_axis_tready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.m_axis_tready = 1'b1;
            end
            vv = '0;
            dd = '0;
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() > 0) begin
                    vv[i] = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
                    dd[i*WIDTH +: WIDTH] = src_q[i][0];
                end
            end
            bus.s_axis_tvalid = vv;
            bus.s_axis_tdata  = dd;
            #1;
            if (!rst) begin
                check("ready_onehot", 64'($countones(bus.s_axis_tready) > 1), 64'd0);
                stalled = bus.m_axis_tvalid && !bus.m_axis_tready;
                fire = vv & bus.s_axis_tready;
                if (fire != '0) begin
                    idx = 0;
                    for (int i = 0; i < N; i++) if (fire[i]) idx = i;
                    void'(src_q[idx].pop_front());
                    if (idx == run_tid) run++;
                    else begin run = 1; run_tid = idx; end
                    if (run > max_run[idx]) max_run[idx] = run;
                    check("burst_le_8", 64'(run > 8), 64'd0);
                    idle_total  += idle_pending;
                    idle_pending = 0;
                    seen_fire    = 1'b1;
                    fires++;
                end else if (!stalled && bus.s_axis_tready == '0) begin
                    run = 0;
                    if (seen_fire) idle_pending++;
                end
            end
        end
    end

    // Scoreboard monitor on the merged stream.
    initial begin
        bit    prev_stalled;
        beat_t prev, cur, e;
        logic [WIDTH-1:0] ed;
        prev_stalled = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk); #2;
            cur = {bus.m_axis_tid, bus.m_axis_tdata};
            if (!rst && !sb_off) begin
                if (prev_stalled) begin
                    check("stall_hold_valid", 64'(bus.m_axis_tvalid), 64'd1);
                    check("stall_hold_beat",  64'(cur), 64'(prev));
                end
                if (bus.m_axis_tvalid && !bus.m_axis_tready)
                    check("stall_s_ready", 64'(bus.s_axis_tready), 64'd0);
                if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                    if (per_tid) begin
                        if (exp_tid_q[cur.tid].size() == 0) begin
                            n_vec++; n_err++;
                            $display("FAIL unexpected_beat: got tid %0d data %0h, expected none", cur.tid, cur.data);
                        end else begin
                            ed = exp_tid_q[cur.tid].pop_front();
                            check("tid_order_data", 64'(cur.data), 64'(ed));
                        end
                    end else begin
                        if (exp_q.size() == 0) begin
                            n_vec++; n_err++;
                            $display("FAIL unexpected_beat: got tid %0d data %0h, expected none", cur.tid, cur.data);
                        end else begin
                            e = exp_q.pop_front();
                            check("beat_tid_data", 64'(cur), 64'(e));
                        end
                    end
                end
                prev_stalled = bus.m_axis_tvalid && !bus.m_axis_tready;
                prev = cur;
            end else begin
                prev_stalled = 1'b0;
            end
        end
    end

    initial begin
        do_reset();

        // All requesters busy: grants 0..3, 8 beats each, one idle cycle per handover.
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 8; k++) push(i, WIDTH'(i + 1));
        drain(300);
        for (int i = 0; i < N; i++) check("all_valid_run", 64'(max_run[i]), 64'd8);
        check("all_valid_idle", 64'(idle_total), 64'd3);

        // Single requester with 20 beats: bursts 8, 8, 4.
        do_reset();
        for (int k = 0; k < 20; k++) push(2, 32'h200 + WIDTH'(k));
        drain(300);
        check("single_run", 64'(max_run[2]), 64'd8);
        check("single_idle", 64'(idle_total), 64'd2);
        check("single_beats", 64'(fires), 64'd20);

        // Requester 1 drops after 3 beats, grant moves to 3.
        do_reset();
        for (int k = 0; k < 3; k++) push(1, 32'h100 + WIDTH'(k));
        for (int k = 0; k < 8; k++) push(3, 32'h300 + WIDTH'(k));
        drain(300);
        check("drop_run1", 64'(max_run[1]), 64'd3);
        check("drop_run3", 64'(max_run[3]), 64'd8);

        // Downstream stall of 5 cycles mid-burst keeps the grant.
        do_reset();
        for (int k = 0; k < 8; k++) push(0, 32'h400 + WIDTH'(k));
        wait_fires(3, 100);
        stall_left = 5;
        drain(300);
        check("stall_run", 64'(max_run[0]), 64'd8);
        check("stall_beats", 64'(fires), 64'd8);

        // Reset during a burst on requester 1, then arbitration restarts at requester 0.
        do_reset();
        sb_off = 1'b1;
        for (int k = 0; k < 8; k++) push(1, 32'h600 + WIDTH'(k));
        wait_fires(3, 100);
        rst = 1'b1;
        #1;
        check("midrst_m_valid", 64'(bus.m_axis_tvalid), 64'd0);
        check("midrst_s_ready", 64'(bus.s_axis_tready), 64'd0);
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        @(negedge clk); @(negedge clk); #3;
        rst = 1'b0;
        sb_off = 1'b0;
        clear_metrics();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 8; k++) push(i, 32'h50 + WIDTH'(i));
        drain(300);
        check("postrst_idle", 64'(idle_total), 64'd3);

        // Random valid/ready traffic, checked per requester.
        do_reset();
        per_tid = 1'b1;
        rand_mode = 1'b1;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 40; k++) push(i, {8'(i), 24'(k)});
        drain(5000);
        check("rand_beats", 64'(fires), 64'd160);
        rand_mode = 1'b0;
        per_tid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fir_input_arbiter.md
FIR_INPUT_ARBITER -- requirements
Module: fir_input_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the sample data width in bits.
REQ-002 The block SHALL have parameter N_LOG, default 2, setting the requester count N = 2**N_LOG.
REQ-003 The block SHALL have parameter BURST_LOG, default 3, setting the maximum beats per grant, BURST = 2**BURST_LOG.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 s_axis_tvalid  input  N  per-requester valid; bit i belongs to requester i (upstream FIFO i).
REQ-007 s_axis_tready  output  N  per-requester ready; at most one bit high at any time.
REQ-008 s_axis_tdata  input  N*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 m_axis_tvalid  output  1  merged stream valid, registered.
REQ-010 m_axis_tready  input  1  downstream (FIR datapath) ready.
REQ-011 m_axis_tdata  output  WIDTH  merged stream data, registered.
REQ-012 m_axis_tid  output  N_LOG  index of the requester that sourced the current m_axis_tdata, registered.

Function
REQ-013 The block SHALL implement a two-state FSM, IDLE and GRANT, plus a grant index g (N_LOG bits), a last-served index last (N_LOG bits) and a beat counter cnt (BURST_LOG bits).
REQ-014 In IDLE, if any s_axis_tvalid bit is high, the block SHALL load g with the first requester with valid high, searching (last+1), (last+2), ... mod N, clear cnt and enter GRANT on the next edge; otherwise it SHALL stay in IDLE.
REQ-015 In IDLE all s_axis_tready bits SHALL be 0, so arbitration costs exactly one cycle with no data accepted.
REQ-016 In GRANT, s_axis_tready[g] SHALL equal (~m_axis_tvalid | m_axis_tready) combinationally; all other ready bits SHALL be 0.
REQ-017 A beat SHALL transfer in when s_axis_tvalid[g] & s_axis_tready[g]; on that edge m_axis_tdata <= s_axis_tdata[g], m_axis_tid <= g, m_axis_tvalid <= 1, cnt <= cnt+1.
REQ-018 When no input beat transfers and m_axis_tready is 1, m_axis_tvalid SHALL clear to 0; m_axis_tdata and m_axis_tid SHALL hold.
REQ-019 m_axis_tdata, m_axis_tid and m_axis_tvalid SHALL be stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-020 GRANT SHALL end (next state IDLE, last <= g) on the edge where a beat transfers with cnt = BURST-1, i.e. after exactly BURST beats.
REQ-021 GRANT SHALL also end (next state IDLE, last <= g) on any edge where s_axis_tvalid[g] = 0, regardless of cnt.
REQ-022 A stall from m_axis_tready = 0 SHALL NOT end GRANT; the grant holds until REQ-020 or REQ-021 fires.
REQ-023 Throughput SHALL be one beat per cycle during GRANT when downstream is always ready; input-to-output latency SHALL be one cycle.
REQ-024 The cnt wrap from BURST-1 to 0 SHALL coincide with the grant release; cnt is cleared on every IDLE to GRANT entry.
REQ-025 No beat SHALL be dropped or duplicated; the order within a requester's stream SHALL be preserved.

Reset
REQ-026 While rst = 1: state = IDLE, g = 0, last = N-1 (requester 0 has first priority), cnt = 0, m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tid = 0, s_axis_tready = 0.
REQ-027 Reset asserted mid-burst SHALL immediately discard the output register contents and the grant; after release the first arbitration SHALL restart from requester 0.

Verification
REQ-028 Reset then all N valids high with constant data i+1 per requester, m_axis_tready=1 -> grants 0,1,2,3 in order, 8 beats each, tid matches, one idle cycle between bursts.
REQ-029 Only requester 2 valid, 20 beats, m_axis_tready=1 -> bursts of 8,8,4 all with tid=2, one IDLE cycle between bursts, no data loss.
REQ-030 Requester 1 valid for 3 beats then drops while requester 3 stays valid -> grant 1 releases after 3 beats, next grant goes to 3.
REQ-031 Burst on requester 0 with m_axis_tready held low for 5 cycles mid-burst -> s_axis_tready[0]=0 during stall, output frozen, grant kept, burst completes at 8 beats.
REQ-032 Assert rst during beat 4 of a burst on requester 1 -> m_axis_tvalid=0 and all s_axis_tready=0 immediately; after release with all valid, first grant is requester 0.
REQ-033 Random valid/ready traffic with scoreboard per tid -> per-requester order preserved, never more than one s_axis_tready bit high, never more than 8 consecutive beats per grant.
